// File: rtl/dmem_pkg.sv
// Shared types and constants for the vector data-memory write-back path.
// The store-entry layout is sized for the default 192-bit / 150000-word geometry.
package dmem_pkg;

  localparam int unsigned LANE_W   = 8;
  localparam int unsigned V_DEF    = 192;
  localparam int unsigned SIZE_DEF = 150000;

  function automatic int unsigned dmem_aw(input int unsigned size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  localparam int unsigned AW_DEF = dmem_aw(SIZE_DEF);

  typedef enum logic [1:0] {
    IDLE,
    VWR,
    RMW_RD,
    RMW_WR
  } wr_state_t;

  typedef struct packed {
    logic              vec_op;
    logic [AW_DEF-1:0] addr;
    logic [V_DEF-1:0]  data;
    logic              oor;
  } st_entry_t;

endpackage

// File: rtl/dmem_wr_store_fifo.sv
// In-order store queue: DEPTH slots of W-bit entries with occupancy count.
// Push while full and pop while empty are ignored.
module store_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  slots [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = slots[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= din;
  end

endmodule

// File: rtl/dmem_wr.sv
// Vector data-memory write-back unit: queued stores committed into a SIZE-word RAM
// as full-vector writes or lane-0 read-modify-writes, plus a registered read port.
module dmem_wr
  import dmem_pkg::*;
#(
  parameter int unsigned V     = V_DEF,
  parameter int unsigned SIZE  = SIZE_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic         VecOp,
  input  logic [V-1:0] address,
  input  logic [V-1:0] wd,
  input  logic [V-1:0] rd_address,
  output logic [V-1:0] rd,
  output logic         idle,
  output logic         err
);

  localparam int unsigned AW = dmem_aw(SIZE);
  localparam int unsigned EW = $bits(st_entry_t);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  st_entry_t     push_entry;
  st_entry_t     head;
  logic          full;
  logic          empty;
  logic          pop;
  logic [CW-1:0] fifo_count;

  wr_state_t     state_q;
  wr_state_t     state_d;
  logic [V-1:0]  m_q;
  logic          m_load;
  logic          mem_we;
  logic [V-1:0]  mem_wdata;
  logic          err_set;

  logic [V-1:0]  mem [SIZE];

  logic          unused_bits;
  assign unused_bits = ^{rd_address[V-1:AW], m_q[LANE_W-1:0], fifo_count};

  always_comb begin
    push_entry.vec_op = VecOp;
    push_entry.addr   = address[AW-1:0];
    push_entry.data   = wd;
    push_entry.oor    = (32'(address[AW-1:0]) >= SIZE) || (address[V-1:AW] != '0);
  end

  store_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_store_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (st_valid && st_ready),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign st_ready = !full;
  assign idle     = empty && (state_q == IDLE);

  // Out-of-range heads still walk the normal state sequence; only the RAM write is gated.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    m_load    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = head.data;
    err_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) state_d = head.vec_op ? VWR : RMW_RD;
      end
      VWR: begin
        pop     = 1'b1;
        mem_we  = !head.oor;
        err_set = head.oor;
        state_d = IDLE;
      end
      RMW_RD: begin
        m_load  = 1'b1;
        state_d = RMW_WR;
      end
      RMW_WR: begin
        pop       = 1'b1;
        mem_we    = !head.oor;
        err_set   = head.oor;
        mem_wdata = {m_q[V-1:LANE_W], head.data[LANE_W-1:0]};
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      err     <= 1'b0;
      rd      <= '0;
    end else begin
      state_q <= state_d;
      if (m_load)  m_q <= mem[head.addr];
      if (err_set) err <= 1'b1;
      rd <= mem[rd_address[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[head.addr] <= mem_wdata;
  end

endmodule
